// File: rtl/ps02_checker.sv
// ps02_checker: scoreboard for the PS02 ALU; optional first-failure capture under PS02_CHK_CAPTURE_EN.
// Latency: stimulus delayed LATENCY cycles to line up with R; verdict registered 1 cycle after the R sample.
// Backpressure: none; stimulus and R are consumed every cycle, noop op F is skipped.
module ps02_checker #(
    parameter int data_width = 32,
    parameter int LATENCY    = 1,
    parameter int SWEEPS     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] A,
    input  logic [data_width-1:0] B,
    input  logic [3:0]            op,
    input  logic [data_width-1:0] R,
    output logic                  mismatch,
    output logic [15:0]           err_cnt,
    output logic [15:0]           chk_cnt,
    output logic                  done,
    output logic                  pass,
    output logic [3:0]            err_op,
    output logic [data_width-1:0] err_exp,
    output logic [data_width-1:0] err_got
);

    localparam int PRIME_CYC  = (LATENCY == 0) ? 1 : LATENCY;
    localparam int CHK_TARGET = SWEEPS * 15;
    localparam logic [data_width-1:0] ONE = {{(data_width-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_PRIME, S_RUN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [3:0]            prime_cnt;
    logic                  prime_last;
    logic [data_width-1:0] d_a, d_b, exp_val;
    logic [3:0]            d_op;
    logic                  run, do_cmp, is_bad;
    logic [15:0]           chk_next;

    // Stimulus delay line, aligning A/B/op with the DUT result they produce
    generate
        if (LATENCY == 0) begin : g_nodelay
            assign d_a  = A;
            assign d_b  = B;
            assign d_op = op;
        end else begin : g_delay
            logic [data_width-1:0] dl_a [LATENCY];
            logic [data_width-1:0] dl_b [LATENCY];
            logic [3:0]            dl_op[LATENCY];

            // Shift a new stimulus word in every cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        dl_a[i]  <= '0;
                        dl_b[i]  <= '0;
                        dl_op[i] <= '0;
                    end
                end else begin
                    dl_a[0]  <= A;
                    dl_b[0]  <= B;
                    dl_op[0] <= op;
                    for (int i = 1; i < LATENCY; i++) begin
                        dl_a[i]  <= dl_a[i-1];
                        dl_b[i]  <= dl_b[i-1];
                        dl_op[i] <= dl_op[i-1];
                    end
                end
            end

            assign d_a  = dl_a[LATENCY-1];
            assign d_b  = dl_b[LATENCY-1];
            assign d_op = dl_op[LATENCY-1];
        end
    endgenerate

    // Reference ALU on the delayed stimulus
    always_comb begin
        exp_val = '0;
        case (d_op)
            4'h0: exp_val = d_a - d_b;
            4'h1: exp_val = d_a + d_b;
            4'h2: exp_val = ~(d_a & d_b);
            4'h3: exp_val = d_a & d_b;
            4'h4: exp_val = d_a | d_b;
            4'h5: exp_val = ~(d_a | d_b);
            4'h6: exp_val = d_a ^ d_b;
            4'h7: exp_val = ~d_a;
            4'h8: exp_val = ~d_b;
            4'h9: exp_val = d_b + ONE;
            4'hA: exp_val = d_a + ONE;
            4'hB: exp_val = d_a - ONE;
            4'hC: exp_val = d_b - ONE;
            4'hD: exp_val = d_a << 1;
            4'hE: exp_val = d_b << 1;
            default: exp_val = '0;
        endcase
    end

    assign prime_last = (prime_cnt == 4'(PRIME_CYC - 1));
    assign do_cmp     = run && (d_op != 4'hF);
    assign is_bad     = do_cmp && (exp_val != R);
    assign chk_next   = (chk_cnt == 16'hFFFF) ? chk_cnt : chk_cnt + 16'd1;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_PRIME;
        else     state <= state_nxt;
    end

    // FSM next state: fill the pipeline, check, then stop once the budget is spent
    always_comb begin
        state_nxt = state;
        case (state)
            S_PRIME: if (prime_last) state_nxt = S_RUN;
            S_RUN:   if (do_cmp && ({16'd0, chk_next} == 32'(CHK_TARGET))) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_PRIME;
        endcase
    end

    // FSM outputs: verdict is only meaningful once done
    always_comb begin
        run  = (state == S_RUN);
        done = (state == S_DONE);
        pass = done && (err_cnt == 16'd0);
    end

    // Pipeline-fill counter used while priming
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  prime_cnt <= '0;
        else if (state == S_PRIME && !prime_last) prime_cnt <= prime_cnt + 4'd1;
    end

    // Registered compare result and saturating counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= 1'b0;
            chk_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            mismatch <= is_bad;
            if (do_cmp) chk_cnt <= chk_next;
            if (is_bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

`ifdef PS02_CHK_CAPTURE_EN
    logic cap_vld;

    // Latch op/expected/actual of the first failure after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld <= 1'b0;
            err_op  <= '0;
            err_exp <= '0;
            err_got <= '0;
        end else if (is_bad && !cap_vld) begin
            cap_vld <= 1'b1;
            err_op  <= d_op;
            err_exp <= exp_val;
            err_got <= R;
        end
    end
`else
    assign err_op  = '0;
    assign err_exp = '0;
    assign err_got = '0;
`endif

endmodule

// File: tb/tb_ps02_checker.sv
// tb_ps02_checker: randomized stimulus against two checkers (LATENCY=1 and LATENCY=0).
// Latency: model is advanced at each rising edge and compared at the following falling edge.
// Backpressure: none; stimulus is driven every cycle.
module tb_ps02_checker;
    localparam int DW = 32;
    localparam int HN = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] A = '0, B = '0, R1 = '0, R0 = '0;
    logic [3:0]    op = '0;

    logic          mis1, mis0, done1, done0, pass1, pass0;
    logic [15:0]   ec1, cc1, ec0, cc0;
    logic [3:0]    eo1, eo0;
    logic [DW-1:0] ee1, eg1, ee0, eg0;

    always #5 clk = ~clk;

    ps02_checker #(.data_width(DW), .LATENCY(1), .SWEEPS(2)) u_dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .op(op), .R(R1),
        .mismatch(mis1), .err_cnt(ec1), .chk_cnt(cc1), .done(done1), .pass(pass1),
        .err_op(eo1), .err_exp(ee1), .err_got(eg1)
    );

    ps02_checker #(.data_width(DW), .LATENCY(0), .SWEEPS(2)) u_dut0 (
        .clk(clk), .rst(rst), .A(A), .B(B), .op(op), .R(R0),
        .mismatch(mis0), .err_cnt(ec0), .chk_cnt(cc0), .done(done0), .pass(pass0),
        .err_op(eo0), .err_exp(ee0), .err_got(eg0)
    );

    int n_chk = 0;
    int n_pass = 0;

    // stimulus history indexed by absolute cycle number
    logic [DW-1:0] ha [HN];
    logic [DW-1:0] hb [HN];
    logic [3:0]    hop[HN];
    int            g = 0;
    logic [3:0]    opn = '0;

    // model state, index 0 = LATENCY 1 instance, 1 = LATENCY 0 instance
    int            k[2], m_chk[2], m_err[2];
    bit            m_mis[2], m_done[2], m_cap[2];
    logic [3:0]    m_eo[2];
    logic [DW-1:0] m_ee[2], m_eg[2];

    int dut_delay = 1;
    bit corrupt   = 1'b0;
    int mis_pulses = 0;

    function automatic logic [DW-1:0] exp_of(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (o)
            4'h0: return a - b;
            4'h1: return a + b;
            4'h2: return ~(a & b);
            4'h3: return a & b;
            4'h4: return a | b;
            4'h5: return ~(a | b);
            4'h6: return a ^ b;
            4'h7: return ~a;
            4'h8: return ~b;
            4'h9: return b + 1;
            4'hA: return a + 1;
            4'hB: return a - 1;
            4'hC: return b - 1;
            4'hD: return a << 1;
            4'hE: return b << 1;
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; m_chk[i] = 0; m_err[i] = 0;
            m_mis[i] = 0; m_done[i] = 0; m_cap[i] = 0;
            m_eo[i] = '0; m_ee[i] = '0; m_eg[i] = '0;
        end
    endtask

    // One rising edge of the checker as the spec describes it, for instance i
    task automatic model_edge(input int i, input int lat, input logic [DW-1:0] r);
        int            pc;
        int            j;
        logic [DW-1:0] e;
        pc = (lat == 0) ? 1 : lat;
        m_mis[i] = 0;
        if (!m_done[i] && k[i] >= pc) begin
            j = g - lat;
            if (hop[j] != 4'hF) begin
                e = exp_of(hop[j], ha[j], hb[j]);
                if (m_chk[i] < 65535) m_chk[i]++;
                if (e !== r) begin
                    m_mis[i] = 1;
                    if (m_err[i] < 65535) m_err[i]++;
                    if (!m_cap[i]) begin
                        m_cap[i] = 1; m_eo[i] = hop[j]; m_ee[i] = e; m_eg[i] = r;
                    end
                end
                if (m_chk[i] == 30) m_done[i] = 1;
            end
        end
        k[i]++;
    endtask

    task automatic compare_all();
        check("mismatch1", mis1, m_mis[0]);
        check("err_cnt1", ec1, m_err[0]);
        check("chk_cnt1", cc1, m_chk[0]);
        check("done1", done1, m_done[0]);
        check("pass1", pass1, m_done[0] && m_err[0] == 0);
        check("mismatch0", mis0, m_mis[1]);
        check("err_cnt0", ec0, m_err[1]);
        check("chk_cnt0", cc0, m_chk[1]);
        check("done0", done0, m_done[1]);
        check("pass0", pass0, m_done[1] && m_err[1] == 0);
`ifdef PS02_CHK_CAPTURE_EN
        check("err_op1", eo1, m_eo[0]);
        check("err_exp1", ee1, m_ee[0]);
        check("err_got1", eg1, m_eg[0]);
        check("err_op0", eo0, m_eo[1]);
        check("err_exp0", ee0, m_ee[1]);
        check("err_got0", eg0, m_eg[1]);
`else
        check("err_op1", eo1, '0);
        check("err_exp1", ee1, '0);
        check("err_got1", eg1, '0);
        check("err_op0", eo0, '0);
`endif
        if (mis1) mis_pulses++;
    endtask

    task automatic step(input bit do_rst);
        logic [3:0] po;
        @(negedge clk);
        if (do_rst) begin
            rst = 1'b1;
            model_reset();
            opn = '0;
            mis_pulses = 0;
            #1;
        end else begin
            rst = 1'b0;
        end
        compare_all();
        op = opn;
        opn = opn + 4'd1;
        if (op == 4'h6) begin
            A = 32'h0000_1279; B = 32'h0000_ADBF;
        end else if (op == 4'h0 && $urandom_range(1, 0) == 1) begin
            A = 32'hFFFF_FFF1; B = 32'd37;
        end else if (op == 4'h9 && $urandom_range(1, 0) == 1) begin
            A = 32'hFFFF_FFFF; B = 32'd0;
        end else begin
            A = $urandom; B = $urandom;
        end
        ha[g] = A; hb[g] = B; hop[g] = op;
        if (g >= dut_delay) begin
            po = hop[g-dut_delay];
            R1 = (corrupt && po == 4'h6) ? '0 : exp_of(po, ha[g-dut_delay], hb[g-dut_delay]);
        end else begin
            R1 = '0;
        end
        R0 = exp_of(op, A, B);
        @(posedge clk);
        if (!rst) begin
            model_edge(0, 1, R1);
            model_edge(1, 0, R0);
        end
        g++;
    endtask

    initial begin
        int guard;
        // pin the model to hand-computed values
        check("model_sub", exp_of(4'h0, 32'hFFFF_FFF1, 32'd37), 32'hFFFF_FFCC);
        check("model_b_inc", exp_of(4'h9, 32'hFFFF_FFFF, 32'd0), 32'd1);
        check("model_xor", exp_of(4'h6, 32'h1279, 32'hADBF), 32'h0000_BFC6);

        // clean run, done held afterwards
        step(1);
        repeat (50) step(0);
        check("clean_chk", cc1, 32'd30);
        check("clean_err", ec1, 32'd0);
        check("clean_done", done1, 32'd1);
        check("clean_pass", pass1, 32'd1);
        check("clean_pass_l0", pass0, 32'd1);
        check("clean_chk_l0", cc0, 32'd30);

        // XOR corrupted in the DUT model
        corrupt = 1'b1;
        step(1);
        repeat (50) step(0);
        corrupt = 1'b0;
        check("xor_err", ec1, 32'd2);
        check("xor_pulses", mis_pulses, 32'd2);
        check("xor_pass", pass1, 32'd0);
        check("xor_done", done1, 32'd1);
`ifdef PS02_CHK_CAPTURE_EN
        check("xor_cap_op", eo1, 32'd6);
        check("xor_cap_exp", ee1, 32'h0000_BFC6);
        check("xor_cap_got", eg1, 32'd0);
`else
        check("xor_nocap_op", eo1, 32'd0);
        check("xor_nocap_exp", ee1, 32'd0);
`endif

        // DUT one cycle slower than the checker expects
        dut_delay = 2;
        step(1);
        repeat (50) step(0);
        dut_delay = 1;
        check("slow_err_nonzero", ec1 != 16'd0, 32'd1);
        check("slow_pass", pass1, 32'd0);
        check("slow_done", done1, 32'd1);

        // reset in the middle of the second sweep, then a full clean run
        step(1);
        guard = 0;
        while (m_chk[0] < 22 && guard < 100) begin
            step(0);
            guard++;
        end
        check("mid_reached", m_chk[0], 32'd22);
        step(1);
        check("mid_rst_chk", cc1, 32'd0);
        check("mid_rst_done", done1, 32'd0);
        repeat (50) step(0);
        check("post_rst_chk", cc1, 32'd30);
        check("post_rst_pass", pass1, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
